// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-fetch responder: state encoding,
// the NOP returned for out-of-range fetches, and default widths.
package imem_responder_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/imem_store.sv
// Instruction store: DEPTH x DATA_W array with one synchronous write port
// and one asynchronous read port. Contents are deliberately not reset.
module imem_store #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Program-image write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/imem_responder.sv
// Responder side of the instruction-fetch interface: one outstanding fetch,
// WAIT_CYC wait states, flushable, with a side port for loading the program.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              flush_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              busy_o,
    input  logic              prog_we_i,
    input  logic [ADDR_W-1:0] prog_addr_i,
    input  logic [DATA_W-1:0] prog_data_i
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      CNT_LOAD  = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);
    localparam logic            ZERO_WAIT = (WAIT_CYC == 0);

    state_e            state_r, state_nxt_s;
    logic [3:0]        cnt_r, cnt_nxt_s;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s;
    logic [DATA_W-1:0] data_r, data_nxt_s;
    logic              err_r, err_nxt_s;
    logic              gnt_s, capture_s, rvalid_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic              rd_in_range_s, wr_en_s;
    logic [DATA_W-1:0] rd_word_s;

    // Grant is also masked by reset so nothing is accepted while held in reset
    assign gnt_s = rst & req_i & ~flush_i & ~prog_we_i
                 & ((state_r == IDLE) | (state_r == RESP));

    assign wr_en_s       = prog_we_i & ({1'b0, prog_addr_i} < DEPTH_EXT);
    assign rd_in_range_s = {1'b0, rd_addr_s} < DEPTH_EXT;

    imem_store #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_store (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr (prog_addr_i[IDX_W-1:0]),
        .wdata (prog_data_i),
        .raddr (rd_addr_s[IDX_W-1:0]),
        .rdata (rd_word_s)
    );

    // Read address: the held PC while waiting, the incoming PC on a zero-wait grant
    always_comb begin
        rd_addr_s = addr_i;
        if (state_r == WAIT) begin
            rd_addr_s = addr_r;
        end else begin
            rd_addr_s = addr_i;
        end
    end

    // Next-state, wait counter and capture of the fetched word
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        addr_nxt_s  = addr_r;
        capture_s   = 1'b0;
        if (gnt_s) begin
            addr_nxt_s = addr_i;
            if (ZERO_WAIT) begin
                state_nxt_s = RESP;
                capture_s   = 1'b1;
            end else begin
                state_nxt_s = WAIT;
                cnt_nxt_s   = CNT_LOAD;
            end
        end else begin
            case (state_r)
                IDLE: state_nxt_s = IDLE;
                WAIT: begin
                    if (flush_i) begin
                        state_nxt_s = IDLE;
                    end else if (cnt_r == 4'd0) begin
                        state_nxt_s = RESP;
                        capture_s   = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r - 4'd1;
                    end
                end
                RESP:    state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end

        data_nxt_s = data_r;
        err_nxt_s  = err_r;
        if (capture_s) begin
            data_nxt_s = rd_in_range_s ? rd_word_s : DATA_W'(NOP_INSTR);
            err_nxt_s  = ~rd_in_range_s;
        end else begin
            data_nxt_s = data_r;
            err_nxt_s  = err_r;
        end
    end

    // FSM and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            addr_r  <= '0;
            data_r  <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            addr_r  <= addr_nxt_s;
            data_r  <= data_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Flush kills the response in the same cycle
    assign rvalid_s = (state_r == RESP) & ~flush_i;
    assign gnt_o    = gnt_s;
    assign rvalid_o = rvalid_s;
    assign rdata_o  = data_r;
    assign err_o    = rvalid_s & err_r;
    assign busy_o   = (state_r != IDLE);

endmodule
